// File: rtl/bc_tile_pkg.sv
// Shared types and helpers for the BC tile decoder: format codes, palette
// containers, RGB565 expansion and the beats-per-block derivation.
// Optional BC3 alpha decoding is enabled with the BC_TILE_BC3_EN macro.
package bc_tile_pkg;

  localparam logic BC_FMT_BC1 = 1'b0;
  localparam logic BC_FMT_BC3 = 1'b1;

  localparam logic [31:0] RGBA_TRANSPARENT = 32'h0000_0000;
  localparam logic [7:0]  ALPHA_OPAQUE     = 8'hFF;

  // Four RGBA8888 colour entries ({R,G,B,A}) and eight alpha entries.
  typedef logic [3:0][31:0] col_pal_t;
  typedef logic [7:0][7:0]  alpha_pal_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } dec_state_t;

  // Output beats needed to cover the 16 texels of one block.
  function automatic int bc_beats(input int pix_per_beat);
    return 16 / pix_per_beat;
  endfunction

  // RGB565 -> RGB888 by replicating the top bits into the low bits.
  function automatic logic [23:0] expand565(input logic [15:0] c);
    return {c[15:11], c[15:13], c[10:5], c[10:9], c[4:0], c[4:2]};
  endfunction

endpackage

// File: rtl/bc_palette_gen.sv
// Combinational palette generator: turns the two colour endpoints (and, with
// BC_TILE_BC3_EN defined, the format bit and alpha endpoints) into the four
// colour entries and eight alpha entries of a block.
module bc_palette_gen
  import bc_tile_pkg::*;
(
  input  logic [15:0] c0,
  input  logic [15:0] c1,
`ifdef BC_TILE_BC3_EN
  input  logic        fmt,
  input  logic [7:0]  a0,
  input  logic [7:0]  a1,
  output alpha_pal_t  alpha,
`endif
  output col_pal_t    col
);

  logic [23:0] e0;
  logic [23:0] e1;
  logic [23:0] mid2;
  logic [23:0] mid3;
  logic        four_colour;
  logic [9:0]  x0;
  logic [9:0]  x1;
  logic [8:0]  half;

  assign e0 = expand565(c0);
  assign e1 = expand565(c1);

`ifdef BC_TILE_BC3_EN
  // BC3 colour blocks never use the punch-through three-colour mode.
  assign four_colour = (c0 > c1) || (fmt == BC_FMT_BC3);
`else
  assign four_colour = (c0 > c1);
`endif

  // Interpolate the two middle colours channel by channel.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    mid2 = '0;
    mid3 = '0;
    x0   = '0;
    x1   = '0;
    half = '0;
    for (int ch = 0; ch < 3; ch++) begin
      x0   = {2'b00, e0[8*ch +: 8]};
      x1   = {2'b00, e1[8*ch +: 8]};
      half = {1'b0, e0[8*ch +: 8]} + {1'b0, e1[8*ch +: 8]};
      if (four_colour) begin
        mid2[8*ch +: 8] = 8'(((x0 << 1) + x1) / 10'd3);
        mid3[8*ch +: 8] = 8'((x0 + (x1 << 1)) / 10'd3);
      end else begin
        mid2[8*ch +: 8] = half[8:1];
        mid3[8*ch +: 8] = 8'h00;
      end
    end
  end

  assign col[0] = {e0, ALPHA_OPAQUE};
  assign col[1] = {e1, ALPHA_OPAQUE};
  assign col[2] = {mid2, ALPHA_OPAQUE};
  assign col[3] = four_colour ? {mid3, ALPHA_OPAQUE} : RGBA_TRANSPARENT;

`ifdef BC_TILE_BC3_EN
  // Eight-entry alpha ramp, or six entries plus fixed 0x00 / 0xFF.
  always_comb begin
    alpha    = '0;
    alpha[0] = a0;
    alpha[1] = a1;
    if (a0 > a1) begin
      for (int k = 2; k < 8; k++) begin
        alpha[k] = 8'(((11'(8 - k) * {3'b000, a0}) + (11'(k - 1) * {3'b000, a1})) / 11'd7);
      end
    end else begin
      for (int k = 2; k < 6; k++) begin
        alpha[k] = 8'(((11'(6 - k) * {3'b000, a0}) + (11'(k - 1) * {3'b000, a1})) / 11'd5);
      end
      alpha[6] = 8'h00;
      alpha[7] = 8'hFF;
    end
  end
`endif

endmodule

// File: rtl/bc_tile_decoder.sv
// BC1 (optionally BC3) 4x4 block decoder. Accepts one block per handshake and
// streams its 16 texels as RGBA8888, PIX_PER_BEAT texels per beat, with
// back-to-back blocks overlapped on the last beat.
// Optional BC3 support is enabled with the BC_TILE_BC3_EN macro.
module bc_tile_decoder
  import bc_tile_pkg::*;
#(
  parameter int PIX_PER_BEAT = 1,
  parameter int IDX_W        = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_fmt,
  input  logic [127:0]              in_block,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [32*PIX_PER_BEAT-1:0] out_rgba,
  output logic [IDX_W-1:0]          out_base_index,
  output logic                      out_last
);

  localparam int               BEATS     = bc_beats(PIX_PER_BEAT);
  localparam int               LANE_W    = 32 * PIX_PER_BEAT;
  localparam logic [IDX_W-1:0] BASE_STEP = IDX_W'(PIX_PER_BEAT);
  localparam logic [IDX_W-1:0] LAST_BASE = IDX_W'(16 - PIX_PER_BEAT);

  dec_state_t       state;
  col_pal_t         pg_col;
  col_pal_t         pal_r;
  logic [31:0]      idx_r;
  logic             accept;
  logic             advance;
  logic [IDX_W-1:0] next_base;
  logic [LANE_W-1:0] next_rgba;

  col_pal_t         src_pal;
  logic [31:0]      src_idx;
  logic [IDX_W-1:0] src_base;
  logic [3:0]       lane_t;
  logic [31:0]      lane_texel;

`ifdef BC_TILE_BC3_EN
  alpha_pal_t  pg_alpha;
  alpha_pal_t  apal_r;
  alpha_pal_t  src_apal;
  logic [47:0] aidx_r;
  logic [47:0] src_aidx;
  logic        bc3_r;
  logic        src_bc3;
  logic        in_bc3;

  assign in_bc3 = (in_fmt == BC_FMT_BC3);

  bc_palette_gen u_pal (
    .c0    (in_block[63:48]),
    .c1    (in_block[47:32]),
    .fmt   (in_fmt),
    .a0    (in_block[71:64]),
    .a1    (in_block[79:72]),
    .alpha (pg_alpha),
    .col   (pg_col)
  );
`else
  // Format bit and alpha half of the block have no function in a BC1-only build.
  logic unused_bc3_bits;
  assign unused_bc3_bits = ^{in_fmt, in_block[127:64]};

  bc_palette_gen u_pal (
    .c0  (in_block[63:48]),
    .c1  (in_block[47:32]),
    .col (pg_col)
  );
`endif

  assign out_valid = (state == ST_EMIT);
  assign in_ready  = (state == ST_IDLE) || ((state == ST_EMIT) && out_last && out_ready);
  assign accept    = in_valid && in_ready;
  assign advance   = out_valid && out_ready;
  assign next_base = out_base_index + BASE_STEP;

  // Build the next beat: beat 0 of the incoming block on accept, otherwise the
  // following beat of the block already held in the palette registers.
  always_comb begin
    src_pal    = pal_r;
    src_idx    = idx_r;
    src_base   = next_base;
    lane_t     = '0;
    lane_texel = '0;
    next_rgba  = '0;
`ifdef BC_TILE_BC3_EN
    src_apal   = apal_r;
    src_aidx   = aidx_r;
    src_bc3    = bc3_r;
`endif
    if (accept) begin
      src_pal  = pg_col;
      src_idx  = in_block[31:0];
      src_base = '0;
`ifdef BC_TILE_BC3_EN
      src_apal = pg_alpha;
      src_aidx = in_block[127:80];
      src_bc3  = in_bc3;
`endif
    end
    for (int k = 0; k < PIX_PER_BEAT; k++) begin
      lane_t     = src_base + 4'(k);
      lane_texel = src_pal[src_idx[{lane_t, 1'b0} +: 2]];
`ifdef BC_TILE_BC3_EN
      if (src_bc3) begin
        lane_texel[7:0] = src_apal[src_aidx[({2'b00, lane_t} + {1'b0, lane_t, 1'b0}) +: 3]];
      end
`endif
      next_rgba[32*k +: 32] = lane_texel;
    end
  end

  // Control FSM with registered beat outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rstn) begin
      state          <= ST_IDLE;
      out_base_index <= '0;
      out_last       <= 1'b0;
      out_rgba       <= '0;
    end else if (accept) begin
      state          <= ST_EMIT;
      out_base_index <= '0;
      out_last       <= (BEATS == 1);
      out_rgba       <= next_rgba;
    end else if (advance) begin
      if (out_last) begin
        state          <= ST_IDLE;
        out_base_index <= '0;
        out_last       <= 1'b0;
      end else begin
        out_base_index <= next_base;
        out_last       <= (next_base == LAST_BASE);
        out_rgba       <= next_rgba;
      end
    end
  end

  // Capture the block's palette and indices at accept.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are not reset; the FSM guarantees they are written before being read.
    if (accept) begin
      pal_r  <= pg_col;
      idx_r  <= in_block[31:0];
`ifdef BC_TILE_BC3_EN
      apal_r <= pg_alpha;
      aidx_r <= in_block[127:80];
      bc3_r  <= in_bc3;
`endif
    end
  end

endmodule

// File: tb/tb_bc_tile_decoder.sv
// Scoreboard bench for bc_tile_decoder (PIX_PER_BEAT = 4). Accepted blocks are
// decoded by a behavioural model into expected beats; a monitor compares every
// presented beat against the queue head. Define BC_TILE_BC3_EN for BC3 cases.
module tb_bc_tile_decoder;

  localparam int PPB   = 4;
  localparam int BEATS = 16 / PPB;
  localparam int LW    = 32 * PPB;
`ifdef BC_TILE_BC3_EN
  localparam bit BC3_ON = 1'b1;
`else
  localparam bit BC3_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic          in_fmt;
  logic [127:0]  in_block;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_rgba;
  logic [3:0]    out_base_index;
  logic          out_last;

  always #5 clk = ~clk;

  bc_tile_decoder #(.PIX_PER_BEAT(PPB), .IDX_W(4)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_fmt         (in_fmt),
    .in_block       (in_block),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_rgba       (out_rgba),
    .out_base_index (out_base_index),
    .out_last       (out_last)
  );

  typedef struct {
    logic [LW-1:0] rgba;
    logic [3:0]    base;
    logic          last;
  } beat_t;

  beat_t            sb_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  int               bp_mode = 0;
  int               bp_pat  = 0;
  bit               use_dir = 1'b0;
  logic [15:0][31:0] dir_tex;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired, got none, expected completion (t=%0t)", name, $time);
  endtask

  function automatic int ext5(input int v);
    return (v << 3) | (v >> 2);
  endfunction

  function automatic int ext6(input int v);
    return (v << 2) | (v >> 4);
  endfunction

  // Reference decode of one block straight from the format rules.
  function automatic logic [15:0][31:0] model_block(input logic [127:0] blk, input logic fmt);
    logic [15:0][31:0] tex;
    int c0, c1, a0, a1;
    int e0[3], e1[3], m2[3], m3[3];
    int ap[8];
    logic [31:0] pal[4];
    bit four, bc3;
    c0 = int'(blk[63:48]);
    c1 = int'(blk[47:32]);
    a0 = int'(blk[71:64]);
    a1 = int'(blk[79:72]);
    bc3  = BC3_ON && fmt;
    four = (c0 > c1) || bc3;
    e0[0] = ext5((c0 >> 11) & 31); e0[1] = ext6((c0 >> 5) & 63); e0[2] = ext5(c0 & 31);
    e1[0] = ext5((c1 >> 11) & 31); e1[1] = ext6((c1 >> 5) & 63); e1[2] = ext5(c1 & 31);
    for (int ch = 0; ch < 3; ch++) begin
      if (four) begin
        m2[ch] = (2 * e0[ch] + e1[ch]) / 3;
        m3[ch] = (e0[ch] + 2 * e1[ch]) / 3;
      end else begin
        m2[ch] = (e0[ch] + e1[ch]) / 2;
        m3[ch] = 0;
      end
    end
    pal[0] = {8'(e0[0]), 8'(e0[1]), 8'(e0[2]), 8'hFF};
    pal[1] = {8'(e1[0]), 8'(e1[1]), 8'(e1[2]), 8'hFF};
    pal[2] = {8'(m2[0]), 8'(m2[1]), 8'(m2[2]), 8'hFF};
    pal[3] = four ? {8'(m3[0]), 8'(m3[1]), 8'(m3[2]), 8'hFF} : 32'h0;
    ap[0] = a0;
    ap[1] = a1;
    if (a0 > a1) begin
      for (int k = 2; k < 8; k++) ap[k] = ((8 - k) * a0 + (k - 1) * a1) / 7;
    end else begin
      for (int k = 2; k < 6; k++) ap[k] = ((6 - k) * a0 + (k - 1) * a1) / 5;
      ap[6] = 0;
      ap[7] = 255;
    end
    for (int i = 0; i < 16; i++) begin
      tex[i] = pal[(blk >> (2 * i)) & 3];
      if (bc3) tex[i][7:0] = 8'(ap[(blk >> (80 + 3 * i)) & 7]);
    end
    return tex;
  endfunction

  function automatic void push_block(input logic [127:0] blk, input logic fmt);
    logic [15:0][31:0] tex;
    beat_t b;
    tex = use_dir ? dir_tex : model_block(blk, fmt);
    for (int bi = 0; bi < BEATS; bi++) begin
      for (int k = 0; k < PPB; k++) b.rgba[32*k +: 32] = tex[bi * PPB + k];
      b.base = 4'(bi * PPB);
      b.last = (bi == BEATS - 1);
      sb_q.push_back(b);
    end
  endfunction

  // Monitor: compare presented beats and handshake readiness at the negedge.
  initial forever begin
    logic exp_rdy;
    @(negedge clk);
    if (rstn) begin
      exp_rdy = 1'b1;
      if (sb_q.size() > 0) exp_rdy = sb_q[0].last && out_ready;
      check("in_ready", {255'b0, in_ready}, {255'b0, exp_rdy});
      if (sb_q.size() > 0) begin
        check("beat", {out_valid, out_base_index, out_last, out_rgba},
                      {1'b1, sb_q[0].base, sb_q[0].last, sb_q[0].rgba});
        if (out_valid && out_ready) void'(sb_q.pop_front());
      end else begin
        check("idle_valid", {255'b0, out_valid}, 256'b0);
      end
      if (in_valid && in_ready) push_block(in_block, in_fmt);
    end
  end

  // Output backpressure generator.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          out_ready = (bp_pat == 0) || (bp_pat == 3);
          bp_pat    = (bp_pat + 1) % 4;
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic send_block(input logic [127:0] blk, input logic fmt);
    int   waited;
    logic acc;
    waited   = 0;
    acc      = 1'b0;
    in_block = blk;
    in_fmt   = fmt;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!acc && waited < 200);
    if (!acc) timeout_fail("accept_timeout");
    use_dir = 1'b0;
  endtask

  task automatic go_idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    go_idle();
    while (sb_q.size() > 0 && waited < 400) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (sb_q.size() > 0) timeout_fail("drain_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, {255'b0, in_ready}, {255'b0, 1'b1});
    check({tag, "_out_valid"}, {255'b0, out_valid}, 256'b0);
    check({tag, "_out_last"}, {255'b0, out_last}, 256'b0);
    check({tag, "_base"}, {252'b0, out_base_index}, 256'b0);
    check({tag, "_rgba"}, {128'b0, out_rgba}, 256'b0);
  endtask

  function automatic logic [127:0] rand_block();
    logic [127:0] blk;
    blk = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 7) == 0) blk[47:32] = blk[63:48];
    if ($urandom_range(0, 7) == 0) blk[79:72] = blk[71:64];
    return blk;
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_fmt   = 1'b0;
    in_block = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // BC1 four-colour, directed expectations.
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0: dir_tex[i] = 32'hFF0000FF;
        1: dir_tex[i] = 32'h0000FFFF;
        2: dir_tex[i] = 32'hAA0055FF;
        default: dir_tex[i] = 32'h5500AAFF;
      endcase
    end
    use_dir = 1'b1;
    send_block({64'h0, 16'hF800, 16'h001F, 32'hE4E4E4E4}, 1'b0);
    drain();

    // BC1 three-colour, directed expectations.
    for (int i = 0; i < 16; i++) dir_tex[i] = (i < 4) ? 32'h7F007FFF : 32'h00000000;
    use_dir = 1'b1;
    send_block({64'h0, 16'h001F, 16'hF800, 32'hFFFFFFAA}, 1'b0);
    drain();

    // Equal endpoints take the three-colour path.
    send_block({64'h0, 16'h7BEF, 16'h7BEF, 32'h1B1B1B1B}, 1'b0);
    drain();

    // Backpressure pattern 1,0,0,1.
    bp_mode = 2;
    bp_pat  = 0;
    send_block(rand_block(), 1'b0);
    drain();
    bp_mode = 0;

    // Back-to-back blocks with in_valid held high.
    send_block(rand_block(), 1'b0);
    send_block(rand_block(), 1'b0);
    send_block({64'h0, 16'hF800, 16'h001F, 32'hE4E4E4E4}, 1'b0);
    drain();

    // Reset in the middle of a block.
    send_block(rand_block(), 1'b0);
    go_idle();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check_reset_state("midreset");
    sb_q.delete();
    rstn = 1'b1;
    send_block(rand_block(), 1'b0);
    drain();

`ifdef BC_TILE_BC3_EN
    // BC3 with a constant alpha index of 2.
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0: dir_tex[i] = 32'hFF0000DA;
        1: dir_tex[i] = 32'h0000FFDA;
        2: dir_tex[i] = 32'hAA0055DA;
        default: dir_tex[i] = 32'h5500AADA;
      endcase
    end
    use_dir = 1'b1;
    send_block({48'o2222222222222222, 8'h00, 8'hFF, 16'hF800, 16'h001F, 32'hE4E4E4E4}, 1'b1);
    drain();
`endif

    // Randomised traffic with random backpressure and gaps.
    for (int n = 0; n < 60; n++) begin
      int gap;
      bp_mode = $urandom_range(0, 1);
      send_block(rand_block(), 1'($urandom_range(0, 1)));
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        go_idle();
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    bp_mode = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
